cpu_clkgen: RTL and testbench

//  Consumer of the main PLL output: derives the KR580VM80A two-phase timing (8224/GF24 equivalent) from the fast system clock.

---
 rtl/cpu_clkgen_pkg.sv | 21 ++
 rtl/cpu_clkgen_sync_ff.sv | 15 +
 rtl/cpu_clkgen.sv | 64 ++++++
 tb/tb_cpu_clkgen.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cpu_clkgen_pkg.sv
// cpu_clkgen_pkg: shared Micro80 clock timing defaults and the T-state phase decode.
package cpu_clkgen_pkg;
  localparam int DEF_DIV      = 9;
  localparam int DEF_PHI1_LEN = 2;
  localparam int DEF_PHI2_LEN = 5;
  localparam int DEF_SYNC_FF  = 2;
  typedef struct packed {
    logic phi1;
    logic phi2;
    logic phi1_en;
    logic phi2_end;
  } phase_t;
  function automatic phase_t phase_decode(input int unsigned c, input int unsigned p1, input int unsigned p2);
    phase_t p;
    p.phi1     = c < p1;
    p.phi2     = c >= p1 && c < p1 + p2;
    p.phi1_en  = c == 0;
    p.phi2_end = c == p1 + p2 - 1;
    return p;
  endfunction
endpackage

// File: rtl/cpu_clkgen_sync_ff.sv
// sync_ff: DEPTH-stage bit synchronizer with asynchronous clear to 0.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[DEPTH-2:0], d};
  assign q = s[DEPTH-1];
endmodule

// File: rtl/cpu_clkgen.sv
// cpu_clkgen: KR580VM80A two-phase clock, status strobe and phase-aligned RESET/READY
// derived from the fast PLL clock; the CPU is held in reset until the PLL is locked.
module cpu_clkgen
  import cpu_clkgen_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int PHI1_LEN = DEF_PHI1_LEN,
  parameter int PHI2_LEN = DEF_PHI2_LEN,
  parameter int SYNC_FF  = DEF_SYNC_FF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic resin_n,
  input  logic rdyin,
  input  logic sync,
  output logic phi1,
  output logic phi2,
  output logic phi1_en,
  output logic phi2_end,
  output logic ststb_n,
  output logic reset_out,
  output logic ready_out
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  if (PHI1_LEN < 1 || PHI2_LEN < 1 || PHI1_LEN + PHI2_LEN >= DIV || SYNC_FF < 2) begin : g_bad_params
    $error("cpu_clkgen: illegal DIV/PHI1_LEN/PHI2_LEN/SYNC_FF combination");
  end
  logic lock_s, resin_s, rdy_s, resreq_s;
  sync_ff #(.DEPTH(SYNC_FF)) u_lock  (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));
  sync_ff #(.DEPTH(SYNC_FF)) u_resin (.clk(clk), .rst_n(rst_n), .d(resin_n),  .q(resin_s));
  sync_ff #(.DEPTH(SYNC_FF)) u_rdy   (.clk(clk), .rst_n(rst_n), .d(rdyin),    .q(rdy_s));
  assign resreq_s = ~resin_s;
  logic [CW-1:0] cnt, cnt_nxt;
  phase_t ph, ph_nxt;
  logic armed;
  // Outputs are decoded from the next count so they line up with the registered cnt.
  always_comb begin
    cnt_nxt = !lock_s ? LAST : cnt == LAST ? '0 : cnt + CW'(1);
    ph_nxt  = lock_s ? phase_decode(32'(cnt_nxt), PHI1_LEN, PHI2_LEN) : '0;
  end
  // armed holds the SYNC sampled at the end of the phi2_end cycle for the following phi1 window.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= LAST;
      ph        <= '0;
      armed     <= 1'b0;
      ststb_n   <= 1'b1;
      reset_out <= 1'b1;
      ready_out <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      ph        <= ph_nxt;
      armed     <= lock_s & (ph.phi2_end ? sync : armed);
      ststb_n   <= ~(ph_nxt.phi1 & armed);
      reset_out <= ~lock_s | (ph_nxt.phi2_end ? resreq_s : reset_out);
      ready_out <= lock_s & (ph_nxt.phi2_end ? rdy_s : ready_out);
    end
  assign phi1     = ph.phi1;
  assign phi2     = ph.phi2;
  assign phi1_en  = ph.phi1_en;
  assign phi2_end = ph.phi2_end;
endmodule

// File: tb/tb_cpu_clkgen.sv
// tb_cpu_clkgen: directed scenarios; expected output vectors are queued per clock and checked by a monitor.
module tb_cpu_clkgen;
  logic clk = 1'b0;
  logic rst_n, pll_lock, resin_n, rdyin, sync;
  logic phi1, phi2, phi1_en, phi2_end, ststb_n, reset_out, ready_out;
  cpu_clkgen dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .resin_n(resin_n), .rdyin(rdyin), .sync(sync),
    .phi1(phi1), .phi2(phi2), .phi1_en(phi1_en), .phi2_end(phi2_end),
    .ststb_n(ststb_n), .reset_out(reset_out), .ready_out(ready_out)
  );
  always #5 clk = ~clk;
  // Hand-written T-state patterns, bit index = cnt (DIV=9, PHI1_LEN=2, PHI2_LEN=5).
  logic [8:0] p1_pat  = 9'b000000011;
  logic [8:0] p2_pat  = 9'b001111100;
  logic [8:0] p1e_pat = 9'b000000001;
  logic [8:0] p2e_pat = 9'b001000000;
  localparam logic [6:0] RST_V = 7'b0000110;
  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;
  exp_t q[$];
  exp_t e, er;
  int vectors = 0, errors = 0;
  string tag = "reset";
  logic l1, l2, r1, r2, y1, y2, arm;
  int pos;
  logic [6:0] ev, act;
  assign act = {phi1, phi2, phi1_en, phi2_end, ststb_n, reset_out, ready_out};
  task automatic step();
    logic ls, rs, ys, prev_p2e;
    @(posedge clk);
    if (!rst_n) begin
      {l1, l2, r1, r2, y1, y2, arm} = '0;
      pos = 8;
      ev = RST_V;
    end else begin
      ls = l2; rs = ~r2; ys = y2; prev_p2e = ev[3];
      l2 = l1; l1 = pll_lock; r2 = r1; r1 = resin_n; y2 = y1; y1 = rdyin;
      if (!ls) begin
        pos = 8;
        arm = 1'b0;
        ev = RST_V;
      end else begin
        pos = pos == 8 ? 0 : pos + 1;
        ev[6] = p1_pat[pos];
        ev[5] = p2_pat[pos];
        ev[4] = p1e_pat[pos];
        ev[3] = p2e_pat[pos];
        ev[2] = ~(p1_pat[pos] & arm);
        ev[1] = p2e_pat[pos] ? rs : ev[1];
        ev[0] = p2e_pat[pos] ? ys : ev[0];
        arm = prev_p2e ? sync : arm;
      end
    end
    q.push_back('{ev, tag});
    #1;
  endtask
  task automatic run_to(input int n);
    int k = 0;
    while (pos != n && k < 20) begin
      step();
      k++;
    end
    if (pos != n) begin
      errors++;
      $display("FAIL run_to_%0d: model position %0d, required %0d", n, pos, n);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: outputs {phi1 phi2 phi1_en phi2_end ststb_n reset_out ready_out} = %b, required %b at %0t",
                 e.tag, act, e.v, $time);
      end
    end
  end
  initial begin
    rst_n = 0; pll_lock = 0; resin_n = 1; rdyin = 1; sync = 0;
    {l1, l2, r1, r2, y1, y2, arm} = '0; pos = 8; ev = RST_V;
    repeat (3) step();
    rst_n = 1; pll_lock = 1; tag = "phase";
    repeat (30) step();
    tag = "ststb_sync_p2end";
    run_to(6); sync = 1; step(); sync = 0;
    repeat (12) step();
    tag = "ststb_sync_cnt3";
    run_to(3); sync = 1; step(); sync = 0;
    repeat (12) step();
    tag = "resin";
    run_to(3); resin_n = 0; repeat (3) step(); resin_n = 1;
    repeat (27) step();
    tag = "rdyin";
    run_to(4); rdyin = 0; repeat (20) step();
    run_to(4); rdyin = 1; repeat (20) step();
    run_to(1); rdyin = 0; repeat (20) step();
    rdyin = 1; repeat (20) step();
    tag = "lock_loss";
    run_to(3); pll_lock = 0; repeat (12) step();
    pll_lock = 1; repeat (30) step();
    tag = "lock_loss_sync";
    run_to(4); pll_lock = 0; step(); step();
    sync = 1; step(); sync = 0;
    repeat (5) step();
    pll_lock = 1; repeat (30) step();
    tag = "rst_n_mid";
    run_to(5); rst_n = 0;
    #1;
    vectors++;
    if (act !== RST_V) begin
      errors++;
      $display("FAIL rst_n_async: outputs %b, required %b", act, RST_V);
    end
    er = q.pop_back(); er.v = RST_V; q.push_back(er);
    step(); step();
    rst_n = 1;
    repeat (30) step();
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
